// File: rtl/buzz_note_pkg.sv
// Shared note definitions for the piezo tone generator and detector.
// One-hot note codes, note indices and default half-periods.
package buzz_note_pkg;

  typedef logic [4:0] note_t;

  localparam int NOTE_DO  = 0;
  localparam int NOTE_RE  = 1;
  localparam int NOTE_MI  = 2;
  localparam int NOTE_SOL = 3;
  localparam int NOTE_LA  = 4;

  localparam int unsigned HP_DO_DEF  = 382234;
  localparam int unsigned HP_RE_DEF  = 340530;
  localparam int unsigned HP_MI_DEF  = 303380;
  localparam int unsigned HP_SOL_DEF = 255100;
  localparam int unsigned HP_LA_DEF  = 227270;

  localparam int unsigned TOL_DEF     = 4000;
  localparam int unsigned CONFIRM_DEF = 4;
  localparam int unsigned TIMEOUT_DEF = 400000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_LOCKED
  } det_state_e;

  // true when p lies in hp-tol .. hp+tol (no underflow)
  function automatic logic inWin(
    logic [31:0] p,
    logic [31:0] hp,
    logic [31:0] tol
  );
    return (p + tol >= hp) && (p <= hp + tol);
  endfunction

endpackage

// File: rtl/buzz_note_if.sv
// Tone input and note report bundle.
// master = tone source / note consumer, slave = detector.
interface buzz_note_if;
  import buzz_note_pkg::*;

  logic  toneIn;
  note_t noteOut;
  logic  noteValid;
  logic  noteChange;

  modport master (
    output toneIn,
    input  noteOut,
    input  noteValid,
    input  noteChange
  );

  modport slave (
    input  toneIn,
    output noteOut,
    output noteValid,
    output noteChange
  );

endinterface

// File: rtl/tone_sync_edge.sv
// Two-flop synchronizer plus registered any-edge detector.
// edgePulse is one cycle wide per synced transition.
module tone_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic edgePulse
);

  logic s1;
  logic s2;
  logic s3;

  // sync chain, previous-value flop and edge register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      edgePulse <= 1'b0;
    end else begin
      s1        <= in;
      s2        <= s1;
      s3        <= s2;
      edgePulse <= s2 ^ s3;
    end
  end

endmodule

// File: rtl/buzz_note_detect.sv
// Tone half-period meter and note classifier.
// Locks after CONFIRM matching half-periods, drops on mismatch/timeout.
module buzz_note_detect
  import buzz_note_pkg::*;
#(
  parameter int unsigned HP_DO   = HP_DO_DEF,
  parameter int unsigned HP_RE   = HP_RE_DEF,
  parameter int unsigned HP_MI   = HP_MI_DEF,
  parameter int unsigned HP_SOL  = HP_SOL_DEF,
  parameter int unsigned HP_LA   = HP_LA_DEF,
  parameter int unsigned TOL     = TOL_DEF,
  parameter int unsigned CONFIRM = CONFIRM_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic        clk,
  input logic        rst,
  buzz_note_if.slave bus
);

  localparam logic [31:0] TMO  = 32'(TIMEOUT);
  localparam logic [31:0] TW   = 32'(TOL);
  localparam logic [7:0]  CONF = 8'(CONFIRM);

  logic        edgeDet;
  det_state_e  st;
  det_state_e  stNext;
  logic [31:0] cnt;
  logic [31:0] cntNext;
  logic [31:0] cntInc;
  note_t       cand;
  note_t       candNext;
  logic [7:0]  mc;
  logic [7:0]  mcNext;
  note_t       cls;
  logic        hit;
  note_t       noteReg;
  note_t       noteNext;
  logic        chgReg;

  tone_sync_edge uSync (
    .clk       (clk),
    .rst       (rst),
    .in        (bus.toneIn),
    .edgePulse (edgeDet)
  );

  // compare bank: one-hot class of the current count
  always_comb begin
    cls           = '0;
    cls[NOTE_DO]  = inWin(cnt, 32'(HP_DO), TW);
    cls[NOTE_RE]  = inWin(cnt, 32'(HP_RE), TW);
    cls[NOTE_MI]  = inWin(cnt, 32'(HP_MI), TW);
    cls[NOTE_SOL] = inWin(cnt, 32'(HP_SOL), TW);
    cls[NOTE_LA]  = inWin(cnt, 32'(HP_LA), TW);
    hit           = |cls;
  end

  // next state, counter, candidate and note
  always_comb begin
    stNext   = st;
    cntNext  = cnt;
    candNext = cand;
    mcNext   = mc;
    cntInc   = (cnt >= TMO) ? cnt : cnt + 32'd1;
    unique case (st)
      ST_IDLE: begin
        cntNext = '0;
        if (edgeDet) begin
          stNext  = ST_MEASURE;
          cntNext = 32'd1;
        end
      end
      ST_MEASURE: begin
        if (edgeDet) begin
          cntNext = 32'd1;
          if (hit && cls == cand) begin
            mcNext = (mc >= CONF) ? mc : mc + 8'd1;
          end else begin
            candNext = cls;
            mcNext   = hit ? 8'd1 : 8'd0;
          end
          if (mcNext == CONF) stNext = ST_LOCKED;
        end else if (cnt == TMO) begin
          stNext   = ST_IDLE;
          cntNext  = '0;
          candNext = '0;
          mcNext   = '0;
        end else begin
          cntNext = cntInc;
        end
      end
      ST_LOCKED: begin
        if (edgeDet) begin
          cntNext = 32'd1;
          if (cls != cand) begin
            stNext   = ST_MEASURE;
            candNext = cls;
            mcNext   = hit ? 8'd1 : 8'd0;
          end
        end else if (cnt == TMO) begin
          stNext   = ST_IDLE;
          cntNext  = '0;
          candNext = '0;
          mcNext   = '0;
        end else begin
          cntNext = cntInc;
        end
      end
      default: begin
        stNext   = ST_IDLE;
        cntNext  = '0;
        candNext = '0;
        mcNext   = '0;
      end
    endcase
    noteNext = (stNext == ST_LOCKED) ? candNext : '0;
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_IDLE;
      cnt     <= '0;
      cand    <= '0;
      mc      <= '0;
      noteReg <= '0;
      chgReg  <= 1'b0;
    end else begin
      st      <= stNext;
      cnt     <= cntNext;
      cand    <= candNext;
      mc      <= mcNext;
      noteReg <= noteNext;
      chgReg  <= (noteNext != noteReg);
    end
  end

  assign bus.noteOut    = noteReg;
  assign bus.noteValid  = |noteReg;
  assign bus.noteChange = chgReg;

endmodule

// File: tb/tb_buzz_note_detect.sv
// Bench for buzz_note_detect: directed scenarios plus random tones,
// checked every cycle against a run-length note model.
module tb_buzz_note_detect;
  import buzz_note_pkg::*;

  localparam int HPS [5] = '{1000, 1100, 1200, 1300, 1400};
  localparam int TOLV = 20;
  localparam int CONF = 4;
  localparam int TMO  = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  buzz_note_if bus ();

  buzz_note_detect #(
    .HP_DO   (1000),
    .HP_RE   (1100),
    .HP_MI   (1200),
    .HP_SOL  (1300),
    .HP_LA   (1400),
    .TOL     (TOLV),
    .CONFIRM (CONF),
    .TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int chgCnt = 0;
  int cyc = 0;

  bit         started = 0;
  bit         tq [4];
  bit         mEdge;
  bit         hasRef;
  int         since;
  int         runCls;
  int         runLen;
  logic [4:0] expNote;
  logic       expChg;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int classify(int p);
    for (int i = 0; i < 5; i++)
      if (p >= HPS[i] - TOLV && p <= HPS[i] + TOLV) return i;
    return -1;
  endfunction

  // model: a note is held while the latest run of equal
  // classified half-periods is at least CONF long
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < 4; i++) tq[i] = 1'b0;
      mEdge   = 1'b0;
      hasRef  = 1'b0;
      since   = 0;
      runCls  = -1;
      runLen  = 0;
      expNote = '0;
      expChg  = 1'b0;
      started = 1'b1;
    end else begin
      logic [4:0] nn;
      if (mEdge) begin
        if (hasRef) begin
          int c;
          c = classify(since);
          if (c >= 0 && c == runCls) runLen++;
          else begin
            runCls = c;
            runLen = (c >= 0) ? 1 : 0;
          end
        end
        hasRef = 1'b1;
        since  = 1;
      end else if (hasRef) begin
        if (since == TMO) begin
          hasRef = 1'b0;
          since  = 0;
          runCls = -1;
          runLen = 0;
        end else begin
          since++;
        end
      end
      nn = '0;
      if (hasRef && runLen >= CONF) nn[runCls] = 1'b1;
      expChg  = (nn != expNote);
      expNote = nn;
      tq[3] = tq[2];
      tq[2] = tq[1];
      tq[1] = tq[0];
      tq[0] = bus.toneIn;
      mEdge = (tq[2] != tq[3]);
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("noteOut", 32'(bus.noteOut), 32'(expNote));
      chk("noteChange", 32'(bus.noteChange), 32'(expChg));
      chk("noteValid", 32'(bus.noteValid), 32'(|expNote));
    end
    if (bus.noteChange === 1'b1) chgCnt++;
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic tone(int h, int n);
    repeat (n) begin
      cycles(h);
      bus.toneIn = ~bus.toneIn;
    end
  endtask

  int c0;
  int hs [5] = '{1250, 1379, 1380, 1421, 1420};
  logic [4:0] he [5] = '{5'b0, 5'b0, 5'b10000, 5'b0, 5'b10000};

  initial begin
    bus.toneIn = 1'b0;
    rst = 1'b1;
    // 1: reset with toneIn toggling
    repeat (6) begin
      cycles(1);
      bus.toneIn = ~bus.toneIn;
      chk("rstNote", 32'(bus.noteOut), 0);
      chk("rstChg", 32'(bus.noteChange), 0);
    end
    bus.toneIn = 1'b0;
    cycles(1);
    rst = 1'b0;
    cycles(1);
    chk("postRstNote", 32'(bus.noteOut), 0);
    chk("postRstValid", 32'(bus.noteValid), 0);
    chk("postRstChg", 32'(bus.noteChange), 0);
    cycles(TMO + 20);

    // 2: la lock after 5 edges
    c0 = chgCnt;
    tone(1400, 4);
    cycles(5);
    chk("s2Early", 32'(bus.noteOut), 0);
    tone(1400, 1);
    cycles(5);
    chk("s2Lock", 32'(bus.noteOut), 32'h10);
    tone(1400, 1);
    cycles(5);
    chk("s2Hold", 32'(bus.noteOut), 32'h10);
    chk("s2Valid", 32'(bus.noteValid), 1);
    chk("s2Pulses", 32'(chgCnt - c0), 1);

    // 3: la -> do via drop
    c0 = chgCnt;
    tone(1000, 1);
    cycles(5);
    chk("s3Drop", 32'(bus.noteOut), 0);
    tone(1000, 4);
    cycles(5);
    chk("s3Relock", 32'(bus.noteOut), 32'h01);
    chk("s3Pulses", 32'(chgCnt - c0), 2);

    // 4: window boundaries
    for (int i = 0; i < 5; i++) begin
      tone(hs[i], 5);
      cycles(5);
      chk($sformatf("s4hp%0d", hs[i]), 32'(bus.noteOut), 32'(he[i]));
    end

    // 5: timeout while locked
    c0 = chgCnt;
    cycles(1985);
    chk("s5Before", 32'(bus.noteOut), 32'h10);
    cycles(30);
    chk("s5Note", 32'(bus.noteOut), 0);
    chk("s5Valid", 32'(bus.noteValid), 0);
    chk("s5Pulses", 32'(chgCnt - c0), 1);
    bus.toneIn = ~bus.toneIn;
    cycles(10);
    chk("s5Restart", 32'(bus.noteOut), 0);
    tone(1400, 1);
    cycles(5);
    chk("s5OneP", 32'(bus.noteOut), 0);

    // 6: reset while locked
    if (bus.toneIn) tone(1400, 1);
    tone(1400, 6);
    cycles(5);
    chk("s6Lock", 32'(bus.noteOut), 32'h10);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("s6RstNote", 32'(bus.noteOut), 0);
    chk("s6RstChg", 32'(bus.noteChange), 0);
    cycles(1);
    chk("s6RstChg2", 32'(bus.noteChange), 0);
    tone(1400, 4);
    cycles(5);
    chk("s6Partial", 32'(bus.noteOut), 0);
    tone(1400, 1);
    cycles(5);
    chk("s6Relock", 32'(bus.noteOut), 32'h10);

    // random tones, jittered periods and resets
    while (cyc < 84000) begin
      int h;
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
      end
      if ($urandom_range(0, 9) < 7)
        h = HPS[$urandom_range(0, 4)]
          + int'($urandom_range(0, 50)) - 25;
      else
        h = int'($urandom_range(600, 2300));
      tone(h, int'($urandom_range(1, 5)));
    end
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
